// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush and
// an optional multi-cycle MDU occupancy FSM built only when HAZARD_MDU_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_x,
  input  logic [REG_ADDR_W-1:0] rs2_x,
  input  logic [REG_ADDR_W-1:0] rd_x,
  input  logic [REG_ADDR_W-1:0] rs2_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic [1:0]            result_src_x,
  input  logic                  pc_src_x,
  input  logic                  mdu_start_x,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_x,
  output logic                  flush_d,
  output logic                  flush_x,
  output logic                  flush_m,
  output logic [1:0]            forward_a_x,
  output logic [1:0]            forward_b_x,
  output logic                  forward_m,
  output logic                  mdu_busy,
  output logic                  mdu_done
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  logic m_fwd_ok_s;
  logic w_fwd_ok_s;
  logic lw_stall_s;
  logic mdu_stall_s;

  assign m_fwd_ok_s = reg_write_m && (rd_m != REG_ZERO);
  assign w_fwd_ok_s = reg_write_w && (rd_w != REG_ZERO);

  // Operand forwarding into X (M wins over W) and store-data forwarding into M
  always_comb begin
    forward_a_x = 2'b00;
    forward_b_x = 2'b00;
    forward_m   = 1'b0;
    if (m_fwd_ok_s && (rs1_x == rd_m)) begin
      forward_a_x = 2'b10;
    end else if (w_fwd_ok_s && (rs1_x == rd_w)) begin
      forward_a_x = 2'b01;
    end else begin
      forward_a_x = 2'b00;
    end
    if (m_fwd_ok_s && (rs2_x == rd_m)) begin
      forward_b_x = 2'b10;
    end else if (w_fwd_ok_s && (rs2_x == rd_w)) begin
      forward_b_x = 2'b01;
    end else begin
      forward_b_x = 2'b00;
    end
    if (w_fwd_ok_s && (rs2_m == rd_w)) begin
      forward_m = 1'b1;
    end else begin
      forward_m = 1'b0;
    end
  end

  // Load in X whose destination is read by the instruction in D
  always_comb begin
    lw_stall_s = 1'b0;
    if ((result_src_x == 2'b01) && (rd_x != REG_ZERO) &&
        ((rd_x == rs1_d) || (rd_x == rs2_d))) begin
      lw_stall_s = 1'b1;
    end else begin
      lw_stall_s = 1'b0;
    end
  end

`ifdef HAZARD_MDU_EN
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

  // MDU_LAT==2 never loads the counter, so a 1-bit counter suffices there
  localparam int               CNT_W    = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MDU_LAT > 2) ? (MDU_LAT - 3) : 0);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_r;
  mdu_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             mdu_go_s;
  logic             mdu_busy_s;
  logic             mdu_done_s;

  // A taken branch flushes the op in X, so it must not launch the MDU
  assign mdu_go_s = mdu_start_x && !pc_src_x;

  // MDU state and down-counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // MDU next-state, counter update and status decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mdu_stall_s = 1'b0;
    mdu_busy_s  = 1'b0;
    mdu_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (mdu_go_s) begin
          mdu_stall_s = 1'b1;
          mdu_busy_s  = 1'b1;
          if (MDU_LAT == 2) begin
            state_nxt_s = DONE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = BUSY;
            cnt_nxt_s   = CNT_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      BUSY: begin
        mdu_stall_s = 1'b1;
        mdu_busy_s  = 1'b1;
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      DONE: begin
        // Start is ignored here so the op still sitting in X cannot relaunch
        mdu_done_s  = 1'b1;
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  assign mdu_busy = reset_n && mdu_busy_s;
  assign mdu_done = reset_n && mdu_done_s;
`else
  logic unused_mdu_s;

  assign unused_mdu_s = ^{clk, reset_n, mdu_start_x};
  assign mdu_stall_s  = 1'b0;
  assign mdu_busy     = 1'b0;
  assign mdu_done     = 1'b0;
`endif

  assign stall_f = lw_stall_s || mdu_stall_s;
  assign stall_d = lw_stall_s || mdu_stall_s;
  assign stall_x = mdu_stall_s;
  assign flush_m = mdu_stall_s;
  assign flush_d = pc_src_x;
  assign flush_x = pc_src_x || (lw_stall_s && !mdu_stall_s);

endmodule
